// File: rtl/kof_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kof_pkg
//  Brief    : Shared phase/result encodings and default frame constants for
//             the fighter round/match sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package kof_pkg;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_INTRO      = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_KO         = 3'd3,
        PH_ROUND_END  = 3'd4,
        PH_MATCH_OVER = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_P1   = 2'd1,
        RES_P2   = 2'd2,
        RES_DRAW = 2'd3
    } result_t;

    localparam int c_intro_frames = 120;
    localparam int c_ko_frames    = 90;
    localparam int c_wins_needed  = 2;
    localparam int c_max_rounds   = 5;

endpackage
`default_nettype wire

// File: rtl/match_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : match_ctrl_if
//  Brief    : Game-side signals between the match sequencer and its peers.
//  Revision : 1.0 - initial release
// ============================================================================
interface match_ctrl_if;

    logic       vsync;
    logic       start_key;
    logic [7:0] char1_hp;
    logic [7:0] char2_hp;
    logic [5:0] seconds;
    logic       stop;
    logic       round_reset;
    logic [2:0] phase;
    logic [2:0] round_num;
    logic [1:0] p1_wins;
    logic [1:0] p2_wins;
    logic [1:0] round_result;
    logic [1:0] match_winner;

    modport master (
        input  vsync, start_key, char1_hp, char2_hp, seconds,
        output stop, round_reset, phase, round_num, p1_wins, p2_wins,
               round_result, match_winner
    );

    modport slave (
        output vsync, start_key, char1_hp, char2_hp, seconds,
        input  stop, round_reset, phase, round_num, p1_wins, p2_wins,
               round_result, match_winner
    );

endinterface
`default_nettype wire

// File: rtl/frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sync
//  Brief    : Two-flop synchronizer followed by a single-cycle rising-edge
//             detector.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sync (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_async,
    output logic      o_rise
);

    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    // r_sync[2] is the previous synchronized level
    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : match_ctrl
//  Brief    : Best-of-N round/match sequencer: KO/time-up decisions, global
//             freeze and round reload pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module match_ctrl
    import kof_pkg::*;
#(
    parameter int INTRO_FRAMES = c_intro_frames,
    parameter int KO_FRAMES    = c_ko_frames,
    parameter int WINS_NEEDED  = c_wins_needed,
    parameter int MAX_ROUNDS   = c_max_rounds
) (
    input wire logic     clk,
    input wire logic     reset_n,
    match_ctrl_if.master bus
);

    localparam logic [7:0] c_intro_last = 8'(INTRO_FRAMES - 1);
    localparam logic [7:0] c_ko_last    = 8'(KO_FRAMES - 1);
    localparam logic [1:0] c_wins       = 2'(WINS_NEEDED);
    localparam logic [2:0] c_rounds     = 3'(MAX_ROUNDS);

    logic    w_frame_tick;
    logic    w_start_press;
    phase_t  r_state;
    phase_t  w_state_nxt;
    result_t w_decision;
    logic    w_match_done;
    logic    w_intro_entry;

    logic [7:0] r_fcnt;
    logic       r_stop;
    logic       r_round_reset;
    logic [2:0] r_round_num;
    logic [1:0] r_p1_wins;
    logic [1:0] r_p2_wins;
    result_t    r_round_result;
    result_t    r_match_winner;

    frame_sync u_vsync_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (bus.vsync),
        .o_rise  (w_frame_tick)
    );

    frame_sync u_start_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (bus.start_key),
        .o_rise  (w_start_press)
    );

    // KO outranks time-up; a double KO is a draw
    always_comb begin
        w_decision = RES_NONE;
        if (bus.char1_hp == 8'd0 && bus.char2_hp == 8'd0) begin
            w_decision = RES_DRAW;
        end else if (bus.char1_hp == 8'd0) begin
            w_decision = RES_P2;
        end else if (bus.char2_hp == 8'd0) begin
            w_decision = RES_P1;
        end else if (bus.seconds == 6'd0) begin
            if (bus.char1_hp > bus.char2_hp)      w_decision = RES_P1;
            else if (bus.char2_hp > bus.char1_hp) w_decision = RES_P2;
            else                                  w_decision = RES_DRAW;
        end
    end

    assign w_match_done = (r_p1_wins == c_wins) || (r_p2_wins == c_wins) ||
                          (r_round_num == c_rounds);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PH_IDLE:       if (w_start_press) w_state_nxt = PH_INTRO;
            PH_INTRO:      if (w_frame_tick && r_fcnt == c_intro_last) w_state_nxt = PH_FIGHT;
            PH_FIGHT:      if (r_fcnt != 8'd0 && w_decision != RES_NONE) w_state_nxt = PH_KO;
            PH_KO:         if (w_frame_tick && r_fcnt == c_ko_last) w_state_nxt = PH_ROUND_END;
            PH_ROUND_END:  w_state_nxt = w_match_done ? PH_MATCH_OVER : PH_INTRO;
            PH_MATCH_OVER: if (w_start_press) w_state_nxt = PH_IDLE;
            default:       w_state_nxt = PH_IDLE;
        endcase
    end

    assign w_intro_entry = (w_state_nxt == PH_INTRO) && (r_state != PH_INTRO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= PH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fcnt         <= '0;
            r_stop         <= 1'b1;
            r_round_reset  <= 1'b0;
            r_round_num    <= '0;
            r_p1_wins      <= '0;
            r_p2_wins      <= '0;
            r_round_result <= RES_NONE;
            r_match_winner <= RES_NONE;
        end else begin
            r_stop        <= (w_state_nxt != PH_FIGHT);
            r_round_reset <= w_intro_entry;
            // Saturating so a long FIGHT never wraps back into the input guard
            if (w_state_nxt != r_state) begin
                r_fcnt <= '0;
            end else if (w_frame_tick && r_fcnt != 8'hFF) begin
                r_fcnt <= r_fcnt + 8'd1;
            end
            if (w_intro_entry) begin
                r_round_result <= RES_NONE;
            end
            case (r_state)
                PH_IDLE: begin
                    if (w_start_press) begin
                        r_round_num    <= 3'd1;
                        r_p1_wins      <= '0;
                        r_p2_wins      <= '0;
                        r_match_winner <= RES_NONE;
                    end
                end
                PH_FIGHT: begin
                    if (w_state_nxt == PH_KO) begin
                        r_round_result <= w_decision;
                        if (w_decision == RES_P1 && r_p1_wins != 2'd3) r_p1_wins <= r_p1_wins + 2'd1;
                        if (w_decision == RES_P2 && r_p2_wins != 2'd3) r_p2_wins <= r_p2_wins + 2'd1;
                    end
                end
                PH_ROUND_END: begin
                    if (r_p1_wins == c_wins) begin
                        r_match_winner <= RES_P1;
                    end else if (r_p2_wins == c_wins) begin
                        r_match_winner <= RES_P2;
                    end else if (r_round_num == c_rounds) begin
                        if (r_p1_wins > r_p2_wins)      r_match_winner <= RES_P1;
                        else if (r_p2_wins > r_p1_wins) r_match_winner <= RES_P2;
                        else                            r_match_winner <= RES_DRAW;
                    end else begin
                        r_round_num <= r_round_num + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stop         = r_stop;
    assign bus.round_reset  = r_round_reset;
    assign bus.phase        = r_state;
    assign bus.round_num    = r_round_num;
    assign bus.p1_wins      = r_p1_wins;
    assign bus.p2_wins      = r_p2_wins;
    assign bus.round_result = r_round_result;
    assign bus.match_winner = r_match_winner;

endmodule
`default_nettype wire
